// File: rtl/spi_pkg.sv
// Shared definitions for the SPI bus master and its SCLK generator.
// Contents:
//   spi_state_e     master FSM state encoding
//   SS_IDLE         SS level while no transaction is open (SS is active-high)
//   SCLK_IDLE       SCLK level between transfers (idles low)
//   CLK_DIV_DEFAULT default sys_clk cycles per SCLK half-period
package spi_pkg;

   localparam int unsigned STATE_WIDTH     = 3;
   localparam logic        SS_IDLE         = 1'b0;
   localparam logic        SCLK_IDLE       = 1'b0;
   localparam int unsigned CLK_DIV_DEFAULT = 4;

   typedef enum logic [STATE_WIDTH-1:0] {
      StIdle    = 3'd0,
      StSetup   = 3'd1,
      StActive  = 3'd2,
      StShiftLo = 3'd3,
      StShiftHi = 3'd4,
      StHold    = 3'd5
   } spi_state_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK half-period timer for the SPI bus master.
// Ports:
//   sys_clk, rst_n   system clock, synchronous active-low reset
//   en_i             run the half-period counter (cleared while low)
//   toggle_en_i      let SCLK toggle on each tick (SCLK forced idle while low)
//   tick_o           one-cycle strobe at the end of each timed phase
//   rise_o / fall_o  tick that also drives SCLK high / low
//   sclk_o           registered SCLK level
module spi_sclk_gen
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
   input  logic sys_clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic toggle_en_i,
   output logic tick_o,
   output logic rise_o,
   output logic fall_o,
   output logic sclk_o
);

   localparam int unsigned          CNT_WIDTH = $clog2(CLK_DIV + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(CLK_DIV);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 sclk_q, sclk_d;

   // The first phase after enable starts at 0 and therefore lasts CLK_DIV+1
   // cycles, which includes the cycle in which the command was taken; later
   // phases reload to 1 and last exactly CLK_DIV cycles.
   always_comb begin
      tick_o = en_i && (cnt_q == CNT_LAST);
      rise_o = tick_o && toggle_en_i && !sclk_q;
      fall_o = tick_o && toggle_en_i && sclk_q;

      cnt_d = cnt_q;
      if (!en_i) begin
         cnt_d = '0;
      end else if (tick_o) begin
         cnt_d = CNT_WIDTH'(1);
      end else begin
         cnt_d = cnt_q + 1'b1;
      end

      sclk_d = sclk_q;
      if (!toggle_en_i) begin
         sclk_d = SCLK_IDLE;
      end else if (tick_o) begin
         sclk_d = ~sclk_q;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         sclk_q <= SCLK_IDLE;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

   assign sclk_o = sclk_q;

endmodule

// File: rtl/spi_bus_master.sv
// Active SPI initiator: opens a transaction (SS high), shifts chunks of up to
// BUF_SIZE bits (MOSI changes on SCLK fall, MISO sampled on SCLK rise) and
// closes it again, driven by single-cycle commands gated by bus_ready.
// Ports:
//   sys_clk, rst_n                  system clock, synchronous active-low reset
//   cmd_start/next_chunk/finish     command strobes, honoured only while bus_ready=1
//   next_chunk_size, tx_data        chunk length and MOSI bits, sampled with cmd_next_chunk
//   miso_in                         slave data
//   mosi_out, sclk_out, ss_out      driven bus lines
//   comm_active                     SS asserted
//   bus_ready                       command handshake
//   rx_data                         MISO bits of the last chunk, LSB-aligned
// Build option: define SPI_MASTER_LSB_FIRST_EN to shift chunks LSB-first
// (default is MSB-first); timing and handshake are identical.
module spi_bus_master
   import spi_pkg::*;
#(
   parameter int unsigned BUF_SIZE         = 9,
   parameter int unsigned CHUNK_SIZE_WIDTH = $clog2(BUF_SIZE + 1),
   parameter int unsigned CLK_DIV          = CLK_DIV_DEFAULT
) (
   input  logic                        sys_clk,
   input  logic                        rst_n,
   input  logic                        cmd_start,
   input  logic                        cmd_next_chunk,
   input  logic                        cmd_finish,
   input  logic [CHUNK_SIZE_WIDTH-1:0] next_chunk_size,
   input  logic [BUF_SIZE-1:0]         tx_data,
   input  logic                        miso_in,
   output logic                        mosi_out,
   output logic                        sclk_out,
   output logic                        ss_out,
   output logic                        comm_active,
   output logic                        bus_ready,
   output logic [BUF_SIZE-1:0]         rx_data
);

   localparam logic [CHUNK_SIZE_WIDTH-1:0] BUF_LEN = CHUNK_SIZE_WIDTH'(BUF_SIZE);

   spi_state_e                  state_q, state_d;
   logic                        ss_q, ss_d;
   logic                        mosi_q, mosi_d;
   logic                        bus_ready_q, bus_ready_d;
   logic [BUF_SIZE-1:0]         rx_data_q, rx_data_d;
   logic [BUF_SIZE-1:0]         tx_sh_q, tx_sh_d;
   logic [BUF_SIZE-1:0]         rx_sh_q, rx_sh_d;
   logic [CHUNK_SIZE_WIDTH-1:0] bits_left_q, bits_left_d;

   logic [CHUNK_SIZE_WIDTH-1:0] n_clamped;
   logic [BUF_SIZE-1:0]         tx_load, tx_next, rx_shift_in, rx_final;
   logic                        first_bit, next_bit;
   logic                        gen_en, gen_toggle, tick, rise, fall;

   assign n_clamped = (next_chunk_size > BUF_LEN) ? BUF_LEN : next_chunk_size;

`ifdef SPI_MASTER_LSB_FIRST_EN
   logic [CHUNK_SIZE_WIDTH-1:0] n_q, n_d;

   assign tx_load     = tx_data;
   assign first_bit   = tx_data[0];
   assign tx_next     = tx_sh_q >> 1;
   assign next_bit    = tx_sh_q[1];
   // MISO enters at the top; the final shift right-aligns the N captured bits.
   assign rx_shift_in = {miso_in, rx_sh_q[BUF_SIZE-1:1]};
   assign rx_final    = rx_sh_q >> (BUF_LEN - n_q);
`else
   // Left-align the chunk so its bit N-1 sits at the top of the shift register.
   assign tx_load     = tx_data << (BUF_LEN - n_clamped);
   assign first_bit   = tx_load[BUF_SIZE-1];
   assign tx_next     = tx_sh_q << 1;
   assign next_bit    = tx_sh_q[BUF_SIZE-2];
   assign rx_shift_in = {rx_sh_q[BUF_SIZE-2:0], miso_in};
   assign rx_final    = rx_sh_q;
`endif

   assign gen_toggle = (state_q == StShiftLo) || (state_q == StShiftHi);
   assign gen_en     = gen_toggle || (state_q == StSetup) || (state_q == StHold);

   spi_sclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk_gen (
      .sys_clk     (sys_clk),
      .rst_n       (rst_n),
      .en_i        (gen_en),
      .toggle_en_i (gen_toggle),
      .tick_o      (tick),
      .rise_o      (rise),
      .fall_o      (fall),
      .sclk_o      (sclk_out)
   );

   always_comb begin
      state_d     = state_q;
      ss_d        = ss_q;
      mosi_d      = mosi_q;
      bus_ready_d = bus_ready_q;
      rx_data_d   = rx_data_q;
      tx_sh_d     = tx_sh_q;
      rx_sh_d     = rx_sh_q;
      bits_left_d = bits_left_q;
`ifdef SPI_MASTER_LSB_FIRST_EN
      n_d         = n_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (bus_ready_q && cmd_start) begin
               ss_d        = ~SS_IDLE;
               bus_ready_d = 1'b0;
               state_d     = StSetup;
            end
         end
         StSetup: begin
            if (tick) begin
               bus_ready_d = 1'b1;
               state_d     = StActive;
            end
         end
         StActive: begin
            if (!bus_ready_q) begin
               // One-cycle busy gap after an empty chunk.
               bus_ready_d = 1'b1;
            end else if (cmd_next_chunk) begin
               bus_ready_d = 1'b0;
               rx_sh_d     = '0;
               bits_left_d = n_clamped;
`ifdef SPI_MASTER_LSB_FIRST_EN
               n_d         = n_clamped;
`endif
               if (n_clamped == '0) begin
                  rx_data_d = '0;
               end else begin
                  tx_sh_d = tx_load;
                  mosi_d  = first_bit;
                  state_d = StShiftLo;
               end
            end else if (cmd_finish) begin
               bus_ready_d = 1'b0;
               state_d     = StHold;
            end
         end
         StShiftLo: begin
            if (rise) begin
               rx_sh_d = rx_shift_in;
               state_d = StShiftHi;
            end
         end
         StShiftHi: begin
            if (fall) begin
               if (bits_left_q > CHUNK_SIZE_WIDTH'(1)) begin
                  bits_left_d = bits_left_q - 1'b1;
                  tx_sh_d     = tx_next;
                  mosi_d      = next_bit;
                  state_d     = StShiftLo;
               end else begin
                  rx_data_d   = rx_final;
                  bus_ready_d = 1'b1;
                  state_d     = StActive;
               end
            end
         end
         StHold: begin
            if (tick) begin
               ss_d        = SS_IDLE;
               mosi_d      = 1'b0;
               bus_ready_d = 1'b1;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         ss_q        <= SS_IDLE;
         mosi_q      <= 1'b0;
         bus_ready_q <= 1'b1;
         rx_data_q   <= '0;
         tx_sh_q     <= '0;
         rx_sh_q     <= '0;
         bits_left_q <= '0;
`ifdef SPI_MASTER_LSB_FIRST_EN
         n_q         <= '0;
`endif
      end else begin
         state_q     <= state_d;
         ss_q        <= ss_d;
         mosi_q      <= mosi_d;
         bus_ready_q <= bus_ready_d;
         rx_data_q   <= rx_data_d;
         tx_sh_q     <= tx_sh_d;
         rx_sh_q     <= rx_sh_d;
         bits_left_q <= bits_left_d;
`ifdef SPI_MASTER_LSB_FIRST_EN
         n_q         <= n_d;
`endif
      end
   end

   assign ss_out      = ss_q;
   assign comm_active = ss_q;
   assign mosi_out    = mosi_q;
   assign bus_ready   = bus_ready_q;
   assign rx_data     = rx_data_q;

endmodule

// File: tb/tb_spi_bus_master.sv
// Directed self-checking bench for spi_bus_master (CLK_DIV=2, BUF_SIZE=9).
// A small slave model supplies MISO from a bit pattern (index 0 first) and
// logs MOSI at every SCLK rise. Inputs change and outputs are sampled on the
// falling sys_clk edge.
module tb_spi_bus_master;

   localparam int unsigned BUF_SIZE = 9;
   localparam int unsigned CSW      = 4;
   localparam int unsigned CLK_DIV  = 2;

   logic                sys_clk = 1'b0;
   logic                rst_n;
   logic                cmd_start, cmd_next_chunk, cmd_finish;
   logic [CSW-1:0]      next_chunk_size;
   logic [BUF_SIZE-1:0] tx_data;
   logic                miso_in;
   logic                mosi_out, sclk_out, ss_out, comm_active, bus_ready;
   logic [BUF_SIZE-1:0] rx_data;

   int          n_cmp  = 0;
   int          n_fail = 0;
   int          rise_cnt = 0;
   int          miso_base = 0;
   logic [15:0] mosi_log = '0;
   logic [15:0] miso_pat = '0;
   logic [3:0]  miso_idx;

   always #5 sys_clk = ~sys_clk;

   spi_bus_master #(
      .BUF_SIZE         (BUF_SIZE),
      .CHUNK_SIZE_WIDTH (CSW),
      .CLK_DIV          (CLK_DIV)
   ) dut (
      .sys_clk         (sys_clk),
      .rst_n           (rst_n),
      .cmd_start       (cmd_start),
      .cmd_next_chunk  (cmd_next_chunk),
      .cmd_finish      (cmd_finish),
      .next_chunk_size (next_chunk_size),
      .tx_data         (tx_data),
      .miso_in         (miso_in),
      .mosi_out        (mosi_out),
      .sclk_out        (sclk_out),
      .ss_out          (ss_out),
      .comm_active     (comm_active),
      .bus_ready       (bus_ready),
      .rx_data         (rx_data)
   );

   // Slave model: next MISO bit is presented after each rise.
   always_comb miso_idx = 4'(rise_cnt - miso_base);
   assign miso_in = miso_pat[miso_idx];

   always @(posedge sclk_out) begin
      mosi_log = {mosi_log[14:0], mosi_out};
      rise_cnt = rise_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge sys_clk) cmd_start = 1'b1;
      @(negedge sys_clk) cmd_start = 1'b0;
   endtask

   task automatic send_chunk(input logic [CSW-1:0] size, input logic [BUF_SIZE-1:0] data);
      @(negedge sys_clk);
      cmd_next_chunk  = 1'b1;
      next_chunk_size = size;
      tx_data         = data;
      @(negedge sys_clk) cmd_next_chunk = 1'b0;
   endtask

   task automatic wait_ready(output int cycles);
      cycles = 0;
      while (bus_ready !== 1'b1 && cycles < 200) begin
         @(negedge sys_clk);
         cycles++;
      end
   endtask

   initial begin
      int c;
      int r0;
      rst_n           = 1'b0;
      cmd_start       = 1'b0;
      cmd_next_chunk  = 1'b0;
      cmd_finish      = 1'b0;
      next_chunk_size = '0;
      tx_data         = '0;
      repeat (2) @(negedge sys_clk);

      // Reset state
      check("rst_ss", 32'(ss_out), 32'd0);
      check("rst_sclk", 32'(sclk_out), 32'd0);
      check("rst_mosi", 32'(mosi_out), 32'd0);
      check("rst_comm", 32'(comm_active), 32'd0);
      check("rst_ready", 32'(bus_ready), 32'd1);
      check("rst_rx", 32'(rx_data), 32'd0);
      rst_n = 1'b1;

      // Chunk command in IDLE is ignored
      r0 = rise_cnt;
      send_chunk(4'd8, 9'h0FF);
      repeat (4) @(negedge sys_clk);
      check("idle_no_sclk", 32'(rise_cnt - r0), 32'd0);
      check("idle_ss", 32'(ss_out), 32'd0);

      // Open transaction
      pulse_start();
      check("start_ready_low", 32'(bus_ready), 32'd0);
      check("start_ss", 32'(ss_out), 32'd1);
      check("start_comm", 32'(comm_active), 32'd1);
      wait_ready(c);
      check("setup_cycles", 32'(c), 32'd3);

      // 8-bit chunk 0xA5, slave returns 0x3C
      miso_base = rise_cnt;
      miso_pat  = 16'h003C;
      r0        = rise_cnt;
      send_chunk(4'd8, 9'h0A5);
      check("chunk_ready_low", 32'(bus_ready), 32'd0);
      wait_ready(c);
      check("chunk8_latency", 32'(c), 32'd33);
      check("chunk8_rises", 32'(rise_cnt - r0), 32'd8);
      check("chunk8_mosi", 32'(mosi_log[7:0]), 32'h0A5);
      check("chunk8_rx", 32'(rx_data), 32'h03C);
      check("chunk8_sclk_idle", 32'(sclk_out), 32'd0);
      check("chunk8_ss_held", 32'(ss_out), 32'd1);

      // Reset while SCLK is high
      miso_base = rise_cnt;
      send_chunk(4'd4, 9'h00F);
      c = 0;
      while (sclk_out !== 1'b1 && c < 50) begin
         @(negedge sys_clk);
         c++;
      end
      check("midreset_reached_hi", 32'(sclk_out), 32'd1);
      rst_n = 1'b0;
      @(negedge sys_clk);
      check("midreset_ss", 32'(ss_out), 32'd0);
      check("midreset_sclk", 32'(sclk_out), 32'd0);
      check("midreset_ready", 32'(bus_ready), 32'd1);
      check("midreset_rx", 32'(rx_data), 32'd0);
      check("midreset_comm", 32'(comm_active), 32'd0);
      rst_n = 1'b1;

      // Oversized chunk clamps to 9 bits, then an empty chunk
      pulse_start();
      wait_ready(c);
      miso_base = rise_cnt;
      miso_pat  = 16'hFFFF;
      r0        = rise_cnt;
      send_chunk(4'd12, 9'h1FF);
      wait_ready(c);
      check("clamp_latency", 32'(c), 32'd37);
      check("clamp_rises", 32'(rise_cnt - r0), 32'd9);
      check("clamp_rx", 32'(rx_data), 32'h1FF);
      r0 = rise_cnt;
      send_chunk(4'd0, 9'h1FF);
      check("empty_ready_low", 32'(bus_ready), 32'd0);
      wait_ready(c);
      check("empty_latency", 32'(c), 32'd1);
      check("empty_rx", 32'(rx_data), 32'd0);
      check("empty_rises", 32'(rise_cnt - r0), 32'd0);

      // Chunk and finish in the same cycle: chunk wins
      miso_base = rise_cnt;
      miso_pat  = 16'h0000;
      r0        = rise_cnt;
      @(negedge sys_clk);
      cmd_next_chunk  = 1'b1;
      cmd_finish      = 1'b1;
      next_chunk_size = 4'd2;
      tx_data         = 9'h003;
      @(negedge sys_clk);
      cmd_next_chunk = 1'b0;
      cmd_finish     = 1'b0;
      wait_ready(c);
      check("both_latency", 32'(c), 32'd9);
      check("both_rises", 32'(rise_cnt - r0), 32'd2);
      check("both_mosi", 32'(mosi_log[1:0]), 32'h3);
      check("both_ss_held", 32'(ss_out), 32'd1);

      // Chunk command while busy is dropped
      r0 = rise_cnt;
      send_chunk(4'd3, 9'h005);
      cmd_next_chunk  = 1'b1;
      next_chunk_size = 4'd9;
      @(negedge sys_clk) cmd_next_chunk = 1'b0;
      wait_ready(c);
      check("busy_latency", 32'(c), 32'd12);
      repeat (6) @(negedge sys_clk);
      check("busy_rises", 32'(rise_cnt - r0), 32'd3);
      check("busy_mosi", 32'(mosi_log[2:0]), 32'h5);

      // Finish: SS drops CLK_DIV+1 cycles after the command
      @(negedge sys_clk) cmd_finish = 1'b1;
      @(negedge sys_clk) cmd_finish = 1'b0;
      check("finish_ready_low", 32'(bus_ready), 32'd0);
      check("finish_ss_still", 32'(ss_out), 32'd1);
      c = 0;
      while (ss_out !== 1'b0 && c < 50) begin
         @(negedge sys_clk);
         c++;
      end
      check("finish_latency", 32'(c), 32'd3);
      check("finish_comm", 32'(comm_active), 32'd0);
      check("finish_sclk", 32'(sclk_out), 32'd0);
      check("finish_mosi", 32'(mosi_out), 32'd0);
      check("finish_ready", 32'(bus_ready), 32'd1);

      // 4-bit chunk tx=0x001, slave sends 1,1,0,0
      pulse_start();
      wait_ready(c);
      miso_base = rise_cnt;
      miso_pat  = 16'h0003;
      r0        = rise_cnt;
      send_chunk(4'd4, 9'h001);
      wait_ready(c);
      check("order_latency", 32'(c), 32'd17);
      check("order_rises", 32'(rise_cnt - r0), 32'd4);
`ifdef SPI_MASTER_LSB_FIRST_EN
      check("order_mosi", 32'(mosi_log[3:0]), 32'h8);
      check("order_rx", 32'(rx_data), 32'h003);
`else
      check("order_mosi", 32'(mosi_log[3:0]), 32'h1);
      check("order_rx", 32'(rx_data), 32'h00C);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
